// File: rtl/prime_checker.sv
// prime_checker
//   Sequential primality tester. Latches one unsigned candidate on accept,
//   screens the trivial cases, then does trial division by odd divisors
//   d = 3, 5, 7, ... until d divides n (composite) or d*d > n (prime).
//   Each remainder n mod d is computed by a restoring shift-subtract divider
//   that produces one quotient bit per cycle (WIDTH cycles per divisor).
//
//   Ports
//     clk                  in   1      system clock, rising edge
//     reset_n              in   1      synchronous reset, ACTIVE HIGH (1 = reset)
//     candidate            in   WIDTH  number to test, sampled only on accept
//     prime_checker_ready  in   1      start request, level-sampled in IDLE
//     isprime              out  1      verdict, valid with done, held until next accept
//     prime_checker_done   out  1      one-cycle pulse, verdict valid
//     cycle_count          out  32     (PRIME_CHECKER_CYCLE_CNT_EN only) busy cycles
//                                      of the current/last test, saturating
//
//   Build option: define PRIME_CHECKER_CYCLE_CNT_EN to add the cycle_count port.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | waiting for ready; verdict of last test held
//   S_TRIVIAL| screen n<2, n==2/3, even n; otherwise start with d=3
//   S_DIV    | shift-subtract divider, one bit per cycle, WIDTH cycles
//   S_STEP   | inspect remainder, advance d by 2, test d*d > n
//   S_FIN    | done pulse with verdict, back to IDLE
module prime_checker #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] candidate,
    input  logic             prime_checker_ready,
    output logic             isprime,
    output logic             prime_checker_done
`ifdef PRIME_CHECKER_CYCLE_CNT_EN
    ,
    output logic [31:0]      cycle_count
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIVIAL,
        S_DIV,
        S_STEP,
        S_FIN
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   n_q;
    logic [WIDTH-1:0]   d_q;
    logic [WIDTH-1:0]   dvd_q;      // dividend bits still to be shifted into rem
    logic [WIDTH:0]     rem_q;      // one spare bit: shifted rem can reach 2*d
    logic [CNT_W-1:0]   bit_cnt_q;  // down-counter over dividend bits
    logic               isprime_q;
    logic               done_q;

    logic [WIDTH:0]     rem_shift_d;
    logic [WIDTH:0]     d_ext_d;
    logic [WIDTH:0]     rem_d;
    logic [WIDTH-1:0]   d_next_d;
    logic [2*WIDTH-1:0] d_next_ext_d;
    logic [2*WIDTH-1:0] d_sq_d;
    logic [2*WIDTH-1:0] n_ext_d;

    // One restoring-division step.
    always_comb begin
        rem_shift_d = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        d_ext_d     = {1'b0, d_q};
        rem_d       = (rem_shift_d >= d_ext_d) ? (rem_shift_d - d_ext_d) : rem_shift_d;
    end

    // Square of the next divisor at double width so it can never wrap below n.
    always_comb begin
        d_next_d     = d_q + WIDTH'(2);
        d_next_ext_d = {{WIDTH{1'b0}}, d_next_d};
        d_sq_d       = d_next_ext_d * d_next_ext_d;
        n_ext_d      = {{WIDTH{1'b0}}, n_q};
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            d_q       <= '0;
            dvd_q     <= '0;
            rem_q     <= '0;
            bit_cnt_q <= '0;
            isprime_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (prime_checker_ready) begin
                        n_q       <= candidate;
                        isprime_q <= 1'b0;
                        state_q   <= S_TRIVIAL;
                    end
                end
                S_TRIVIAL: begin
                    if (n_q < WIDTH'(2)) begin
                        isprime_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_FIN;
                    end else if (n_q == WIDTH'(2) || n_q == WIDTH'(3)) begin
                        isprime_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= S_FIN;
                    end else if (!n_q[0]) begin
                        isprime_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_FIN;
                    end else begin
                        d_q       <= WIDTH'(3);
                        rem_q     <= '0;
                        dvd_q     <= n_q;
                        bit_cnt_q <= CNT_W'(WIDTH - 1);
                        state_q   <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                    if (bit_cnt_q == '0) begin
                        state_q <= S_STEP;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - CNT_W'(1);
                    end
                end
                S_STEP: begin
                    if (rem_q == '0) begin
                        isprime_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_FIN;
                    end else begin
                        d_q <= d_next_d;
                        if (d_sq_d > n_ext_d) begin
                            isprime_q <= 1'b1;
                            done_q    <= 1'b1;
                            state_q   <= S_FIN;
                        end else begin
                            rem_q     <= '0;
                            dvd_q     <= n_q;
                            bit_cnt_q <= CNT_W'(WIDTH - 1);
                            state_q   <= S_DIV;
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign isprime            = isprime_q;
    assign prime_checker_done = done_q;

`ifdef PRIME_CHECKER_CYCLE_CNT_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            cyc_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (prime_checker_ready) begin
                cyc_q <= '0;
            end
        end else if (cyc_q != 32'hFFFF_FFFF) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign cycle_count = cyc_q;
`endif

endmodule

// File: tb/tb_prime_checker.sv
module tb_prime_checker;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] cand32;
    logic        rdy32;
    logic        p32;
    logic        done32;
    logic [7:0]  cand8;
    logic        rdy8;
    logic        p8;
    logic        done8;
`ifdef PRIME_CHECKER_CYCLE_CNT_EN
    logic [31:0] cc32;
    logic [31:0] cc8;
`endif

    int checks = 0;
    int errors = 0;

    prime_checker #(.WIDTH(32)) dut32 (
        .clk                 (clk),
        .reset_n             (rst),
        .candidate           (cand32),
        .prime_checker_ready (rdy32),
        .isprime             (p32),
        .prime_checker_done  (done32)
`ifdef PRIME_CHECKER_CYCLE_CNT_EN
        ,
        .cycle_count         (cc32)
`endif
    );

    // Narrow instance: lets the d*d no-wrap boundary be reached in a few cycles.
    prime_checker #(.WIDTH(8)) dut8 (
        .clk                 (clk),
        .reset_n             (rst),
        .candidate           (cand8),
        .prime_checker_ready (rdy8),
        .isprime             (p8),
        .prime_checker_done  (done8)
`ifdef PRIME_CHECKER_CYCLE_CNT_EN
        ,
        .cycle_count         (cc8)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain trial division from the rules, latency from divisor count.
    function automatic void ref_eval(input longint unsigned n, input int w,
                                     output bit p, output int lat);
        longint unsigned d;
        int k;
        if (n < 2) begin
            p = 0; lat = 2;
        end else if (n == 2 || n == 3) begin
            p = 1; lat = 2;
        end else if (n % 2 == 0) begin
            p = 0; lat = 2;
        end else begin
            d = 3; k = 0;
            forever begin
                k++;
                if (n % d == 0) begin p = 0; break; end
                d += 2;
                if (d * d > n) begin p = 1; break; end
            end
            lat = 2 + k * (w + 1);
        end
    endfunction

    // Starts one test, returns verdict and cycles from accept edge to done cycle.
    // dis_at > 0: at that cycle change candidate and pulse ready (must be ignored).
    task automatic run_one(input bit sel, input logic [31:0] n, input int dis_at,
                           output logic got_p, output int got_lat);
        bit found;
        @(negedge clk);
        if (sel) begin cand8 = n[7:0]; rdy8 = 1'b1; end
        else begin cand32 = n; rdy32 = 1'b1; end
        @(posedge clk);
        got_lat = 0;
        found = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            got_lat++;
            if (got_lat == 1) begin
                rdy8 = 1'b0;
                rdy32 = 1'b0;
                check("isprime_clear_on_accept", sel ? p8 : p32, 0);
            end
            if (dis_at > 0 && got_lat == dis_at) begin cand32 = 32'd100; rdy32 = 1'b1; end
            if (dis_at > 0 && got_lat == dis_at + 1) rdy32 = 1'b0;
            if (sel ? done8 : done32) begin found = 1; break; end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL timeout n=%0d: no done within 5000 cycles", n);
        end
        got_p = sel ? p8 : p32;
        @(negedge clk);
        check("done_one_cycle", sel ? done8 : done32, 0);
        check("isprime_held", sel ? p8 : p32, got_p);
`ifdef PRIME_CHECKER_CYCLE_CNT_EN
        check("cycle_count", sel ? cc8 : cc32, got_lat);
`endif
    endtask

    typedef struct {
        logic [31:0] n;
        bit          sel;
        bit          exp_p;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic gp;
        int   gl;
        bit   ep;
        int   el;
        int   ndone;
        logic [31:0] n;

        vecs = '{
            '{32'd41,         0, 1, 68},
            '{32'd47,         0, 1, 68},
            '{32'd101,        0, 1, 134},
            '{32'd409,        0, 1, 299},
            '{32'd23,         0, 1, 35},
            '{32'd408,        0, 0, 2},
            '{32'd26,         0, 0, 2},
            '{32'd25,         0, 0, 68},
            '{32'd9,          0, 0, 35},
            '{32'd0,          0, 0, 2},
            '{32'd1,          0, 0, 2},
            '{32'd2,          0, 1, 2},
            '{32'd3,          0, 1, 2},
            '{32'd4294967295, 0, 0, 35},
            '{32'd251,        1, 1, 65},
            '{32'd255,        1, 0, 11},
            '{32'd253,        1, 0, 47},
            '{32'd5,          1, 1, 11}
        };

        // Reset held three cycles with ready high: nothing may be accepted.
        rst = 1'b1; rdy32 = 1'b1; rdy8 = 1'b1; cand32 = 32'd5; cand8 = 8'd5;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("reset_done", done32, 0);
            check("reset_isprime", p32, 0);
            check("reset_done8", done8, 0);
        end
        rdy32 = 1'b0; rdy8 = 1'b0; rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32 || done8) ndone++;
        end
        check("no_accept_during_reset", ndone, 0);

        // Directed table.
        foreach (vecs[i]) begin
            run_one(vecs[i].sel, vecs[i].n, 0, gp, gl);
            if (gp !== vecs[i].exp_p)
                $display("FAIL vec n=%0d isprime got %0d expected %0d", vecs[i].n, gp, vecs[i].exp_p);
            if (gl != vecs[i].exp_lat)
                $display("FAIL vec n=%0d latency got %0d expected %0d", vecs[i].n, gl, vecs[i].exp_lat);
            checks += 2;
            errors += int'(gp !== vecs[i].exp_p) + int'(gl != vecs[i].exp_lat);
        end

        // Candidate change and ready pulse mid-test are ignored.
        run_one(0, 32'd101, 40, gp, gl);
        check("midtest_verdict", gp, 1);
        check("midtest_latency", gl, 134);

        // Back-to-back: ready held through done, next candidate taken in the IDLE cycle.
        @(negedge clk);
        cand32 = 32'd41; rdy32 = 1'b1;
        @(posedge clk);
        gl = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            gl++;
            if (done32) break;
        end
        check("b2b_first_verdict", p32, 1);
        check("b2b_first_latency", gl, 68);
        cand32 = 32'd23;
        gl = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            gl++;
            if (gl == 2) rdy32 = 1'b0;
            if (done32) break;
        end
        check("b2b_second_verdict", p32, 1);
        check("b2b_second_gap", gl, 36);
        @(negedge clk);

        // Reset mid-DIV aborts without a done pulse.
        @(negedge clk);
        cand32 = 32'd409; rdy32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy32 = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_done", done32, 0);
        check("abort_isprime", p32, 0);
        rst = 1'b0;
        ndone = 0;
        repeat (400) begin
            @(negedge clk);
            if (done32) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run_one(0, 32'd47, 0, gp, gl);
        check("after_abort_verdict", gp, 1);
        check("after_abort_latency", gl, 68);

        // Exhaustive 8-bit sweep against the reference.
        for (int v = 0; v < 256; v++) begin
            ref_eval(longint'(v), 8, ep, el);
            run_one(1, 32'(v), 0, gp, gl);
            if (gp !== ep || gl != el)
                $display("FAIL sweep8 n=%0d got p=%0d lat=%0d expected p=%0d lat=%0d", v, gp, gl, ep, el);
            checks++;
            if (gp !== ep || gl != el) errors++;
        end

        // Random small 32-bit candidates.
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 4095);
            ref_eval(longint'(n), 32, ep, el);
            run_one(0, n, 0, gp, gl);
            if (gp !== ep || gl != el)
                $display("FAIL rand32 n=%0d got p=%0d lat=%0d expected p=%0d lat=%0d", n, gp, gl, ep, el);
            checks++;
            if (gp !== ep || gl != el) errors++;
        end

        // Random large multiples of 3 (full-width datapath, quick to resolve).
        for (int r = 0; r < 10; r++) begin
            n = 32'd3 * 32'($urandom_range(2, 1431655765));
            ref_eval(longint'(n), 32, ep, el);
            run_one(0, n, 0, gp, gl);
            if (gp !== ep || gl != el)
                $display("FAIL big32 n=%0d got p=%0d lat=%0d expected p=%0d lat=%0d", n, gp, gl, ep, el);
            checks++;
            if (gp !== ep || gl != el) errors++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
